// File: rtl/conv_patch_pkg.sv
// Shared types and constants for the convolution-patch sequencer.
package conv_patch_pkg;

  // Two-state scan controller.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Smallest legal patch edge and stride.
  localparam int P_MIN = 1;
  localparam int S_MIN = 1;

  // Coordinate width: enough bits to hold max(IMG_W, IMG_H) itself.
  function automatic int calc_cw(input int w, input int h);
    return $clog2(((w > h) ? w : h) + 1);
  endfunction

endpackage

// File: rtl/conv_patch_seq_therm_enc.sv
// Coordinate to N-bit thermometer code: bit i = (i < coord) when enabled.
module therm_enc #(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic [W-1:0] coord_i,
  input  logic         en_i,
  output logic [N-1:0] therm_o
);

  // Decode every output bit against the coordinate; all-zero when disabled.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves therm_o unassigned (no latch).
    therm_o = '0;
    for (int i = 0; i < N; i++) begin
      therm_o[i] = en_i && (32'(i) < 32'(coord_i));
    end
  end

endmodule

// File: rtl/conv_patch_seq.sv
// Convolution-patch sequencer: one start scans every patch position row-major,
// emitting LANES horizontally adjacent positions per beat as thermometer masks.
module conv_patch_seq
  import conv_patch_pkg::*;
#(
  parameter  int IMG_W = 32,
  parameter  int IMG_H = 32,
  parameter  int MAX_P = 7,
  parameter  int MAX_S = 7,
  parameter  int LANES = 8,
  localparam int CW    = calc_cw(IMG_W, IMG_H)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2:0]             patch_size,
  input  logic [2:0]             stride,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [LANES-1:0]       lane_valid,
  output logic [CW-1:0]          y_pos,
  output logic [CW-1:0]          x_base,
  output logic [IMG_H-1:0]       y_therm,
  output logic [LANES*IMG_W-1:0] x_therm,
  output logic                   last,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  // Extended width so x_base + LANES*MAX_S + MAX_P never wraps.
  localparam int EW = CW + 4;
  typedef logic [EW-1:0] ew_t;

  state_e        state_q;
  logic [2:0]    p_q, s_q;
  logic [CW-1:0] x_base_q, y_pos_q;
  logic          done_q, cfg_err_q;

  logic             run, cfg_ok, hs, row_wrap, last_c;
  logic [CW-1:0]    x_step_d, y_step_d;
  ew_t              lane_x [LANES];
  logic [LANES-1:0] lane_ok;

  assign run = (state_q == RUN);
  assign hs  = run && out_ready;

  assign cfg_ok = (int'(patch_size) >= P_MIN) && (int'(patch_size) <= MAX_P) &&
                  (int'(stride)     >= S_MIN) && (int'(stride)     <= MAX_S) &&
                  (int'(patch_size) <= IMG_W) && (int'(patch_size) <= IMG_H);

  // Per-lane column position and validity (position + patch must fit the row).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_x[l]  = ew_t'(x_base_q) + ew_t'(l) * ew_t'(s_q);
      lane_ok[l] = run && ((lane_x[l] + ew_t'(p_q)) <= ew_t'(IMG_W));
    end
  end

  // The row wraps when the next beat's lane 0 would no longer fit.
  assign row_wrap = (ew_t'(x_base_q) + ew_t'(LANES) * ew_t'(s_q) + ew_t'(p_q)) > ew_t'(IMG_W);
  assign last_c   = run && row_wrap &&
                    ((ew_t'(y_pos_q) + ew_t'(s_q) + ew_t'(p_q)) > ew_t'(IMG_H));

  // Stride accumulation only; no division anywhere.
  assign x_step_d = CW'(ew_t'(x_base_q) + ew_t'(LANES) * ew_t'(s_q));
  assign y_step_d = CW'(ew_t'(y_pos_q) + ew_t'(s_q));

  // Scan controller: state, latched config, coordinates and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      s_q       <= '0;
      x_base_q  <= '0;
      y_pos_q   <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q  <= RUN;
              p_q      <= patch_size;
              s_q      <= stride;
              x_base_q <= '0;
              y_pos_q  <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q  <= IDLE;
            x_base_q <= '0;
            y_pos_q  <= '0;
          end else if (hs) begin
            if (last_c) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              x_base_q <= '0;
              y_pos_q  <= '0;
            end else if (row_wrap) begin
              x_base_q <= '0;
              y_pos_q  <= y_step_d;
            end else begin
              x_base_q <= x_step_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = run;
  assign busy       = run;
  assign lane_valid = lane_ok;
  assign x_base     = x_base_q;
  assign y_pos      = y_pos_q;
  assign last       = last_c;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

  therm_enc #(.N(IMG_H), .W(CW)) u_y_therm (
    .coord_i (y_pos_q),
    .en_i    (1'b1),
    .therm_o (y_therm)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_x_therm
    therm_enc #(.N(IMG_W), .W(EW)) u_x_therm (
      .coord_i (lane_x[l]),
      .en_i    (lane_ok[l]),
      .therm_o (x_therm[l*IMG_W +: IMG_W])
    );
  end

endmodule

// File: tb/tb_conv_patch_seq.sv
// Self-checking bench for conv_patch_seq against a list-of-beats reference model.
module tb_conv_patch_seq;
  import conv_patch_pkg::*;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int LANES = 8;
  localparam int CW    = calc_cw(IMG_W, IMG_H);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [2:0] patch_size = '0, stride = '0;
  logic out_valid, last, busy, done, cfg_err;
  logic [LANES-1:0]       lane_valid;
  logic [CW-1:0]          y_pos, x_base;
  logic [IMG_H-1:0]       y_therm;
  logic [LANES*IMG_W-1:0] x_therm;

  typedef struct {
    int                     x;
    int                     y;
    logic [LANES-1:0]       mask;
    logic [LANES*IMG_W-1:0] xt;
    logic [IMG_H-1:0]       yt;
    bit                     lst;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0, n_fail = 0;
  int beats_seen, final_y;
  logic [LANES*IMG_W-1:0] first_xt;

  conv_patch_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .patch_size(patch_size), .stride(stride), .out_ready(out_ready),
    .out_valid(out_valid), .lane_valid(lane_valid), .y_pos(y_pos), .x_base(x_base),
    .y_therm(y_therm), .x_therm(x_therm), .last(last), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enumerate every patch position directly: rows y with y+P<=H, columns
  // x in steps of LANES*S with x+P<=W; lanes valid where their patch fits.
  function automatic void build(input int p, input int s);
    exp_q.delete();
    for (int y = 0; y + p <= IMG_H; y += s) begin
      for (int x = 0; x + p <= IMG_W; x += LANES * s) begin
        beat_t b;
        b.x = x; b.y = y; b.mask = '0; b.xt = '0; b.lst = 1'b0;
        b.yt = IMG_H'((64'd1 << y) - 64'd1);
        for (int l = 0; l < LANES; l++) begin
          if (x + l * s + p <= IMG_W) begin
            b.mask[l] = 1'b1;
            b.xt[l*IMG_W +: IMG_W] = IMG_W'((64'd1 << (x + l * s)) - 64'd1);
          end
        end
        exp_q.push_back(b);
      end
    end
    exp_q[exp_q.size() - 1].lst = 1'b1;
  endfunction

  // Launch a scan from the current cycle and follow it beat by beat.
  task automatic run_scan(input int p, input int s, input bit rnd, input int abort_at,
                          input string name);
    int k = 0;
    int cyc = 0;
    bit rdy, ov, was_last;
    int obs_y;
    build(p, s);
    start = 1'b1; patch_size = 3'(p); stride = 3'(s);
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    first_xt = x_therm;
    beats_seen = 0;
    final_y = -1;
    while (cyc < 4000) begin
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = rdy;
      if (rnd) begin
        // Starts and config changes while running must be ignored.
        start = 1'(($urandom_range(0, 1)));
        patch_size = 3'($urandom_range(0, 7));
        stride = 3'($urandom_range(0, 7));
      end
      if (k < exp_q.size()) begin
        check({name, "_valid"}, out_valid, 1);
        check({name, "_x"}, x_base, exp_q[k].x);
        check({name, "_y"}, y_pos, exp_q[k].y);
        check({name, "_mask"}, lane_valid, exp_q[k].mask);
        check({name, "_xtherm"}, x_therm, exp_q[k].xt);
        check({name, "_ytherm"}, y_therm, exp_q[k].yt);
        check({name, "_last"}, last, exp_q[k].lst);
        check({name, "_cfgerr"}, cfg_err, 0);
      end else begin
        check({name, "_overrun"}, out_valid, 0);
      end
      if (abort_at == k) begin
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b0;
        check({name, "_abort_valid"}, out_valid, 0);
        check({name, "_abort_busy"}, busy, 0);
        check({name, "_abort_done"}, done, 0);
        @(posedge clk); #1;
        check({name, "_abort_done2"}, done, 0);
        return;
      end
      ov = out_valid;
      was_last = last;
      obs_y = int'(y_pos);
      @(posedge clk); #1;
      cyc++;
      if (!ov) break;
      if (rdy) begin
        beats_seen++;
        final_y = obs_y;
        k++;
        if (was_last) break;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    check({name, "_beats_vs_model"}, beats_seen, exp_q.size());
    check({name, "_done"}, done, 1);
    check({name, "_done_busy"}, busy, 0);
    check({name, "_done_valid"}, out_valid, 0);
  endtask

  task automatic bad_start(input int p, input int s, input string name);
    start = 1'b1; patch_size = 3'(p); stride = 3'(s);
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_cfgerr"}, cfg_err, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_valid"}, out_valid, 0);
    @(posedge clk); #1;
    check({name, "_cfgerr_pulse"}, cfg_err, 0);
    check({name, "_busy2"}, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, out_valid, 0);
    check({name, "_mask"}, lane_valid, 0);
    check({name, "_y"}, y_pos, 0);
    check({name, "_x"}, x_base, 0);
    check({name, "_ytherm"}, y_therm, 0);
    check({name, "_xtherm"}, x_therm, 0);
    check({name, "_last"}, last, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_cfgerr"}, cfg_err, 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Defaults P=3 S=1: 30 rows of 4 beats, last row at y=29.
    run_scan(3, 1, 1'b0, -1, "p3s1");
    check("p3s1_beats", beats_seen, 120);
    check("p3s1_final_y", final_y, 29);

    // Started in the cycle done is high.
    run_scan(7, 7, 1'b0, -1, "p7s7");
    check("p7s7_beats", beats_seen, 4);
    check("p7s7_final_y", final_y, 21);
    check("p7s7_slice1", first_xt[IMG_W +: IMG_W], 32'h0000_007F);

    run_scan(5, 3, 1'b0, -1, "p5s3");
    check("p5s3_beats", beats_seen, 20);
    check("p5s3_final_y", final_y, 27);

    // Backpressure with random stalls and ignored mid-scan starts.
    run_scan(3, 2, 1'b1, -1, "p3s2_bp");
    check("p3s2_beats", beats_seen, 30);
    check("p3s2_final_y", final_y, 28);
    @(posedge clk); #1;
    check("p3s2_done_pulse", done, 0);

    bad_start(0, 1, "bad_p0");
    bad_start(7, 0, "bad_s0");

    run_scan(3, 1, 1'b0, 4, "abort");

    // Asynchronous reset in the middle of a scan.
    start = 1'b1; patch_size = 3'd3; stride = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_y", y_pos, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);
    run_scan(3, 1, 1'b0, -1, "after_rst");
    check("after_rst_beats", beats_seen, 120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
